stream_fifo_arbiter: RTL and testbench
======================================

Name: stream_fifo_arbiter

Overview:
Round-robin scheduler that shares one outbound stream master between N standard (non-FWFT) FIFOs. Each FIFO has 1-cycle read latency. The block issues reads to one granted FIFO at a time, in bursts of up to BURST words, and tags every output word with its source index. It sits between the per-channel sample FIFOs and the single stream consumer (DMA/packetiser), and lets software mask channels out of the rotation.

Parameters:
N, 4, number of FIFO requesters (2..16)
DW, 32, data width per FIFO
BURST, 8, max words read per grant (1..256)
IW, 2, source id width; must equal clog2(N)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_mask_i  in  N  1 = channel eligible for grant; sampled every cycle
fifo_data_i  in  N*DW  FIFO read data, channel k at [k*DW +: DW]; valid the cycle after its rd_en
fifo_rd_en_o  out  N  per-FIFO read strobe, at most one bit high per cycle
fifo_empty_i  in  N  per-FIFO empty flag
stream_m_data_o  out  DW  output data
stream_m_id_o  out  IW  source index of the current output word
stream_m_valid_o  out  1  output valid
stream_m_ready_i  in  1  consumer ready

Behaviour:
- Reset is asynchronous on rst_n low. All of the following go to 0: fifo_rd_en_o, stream_m_valid_o, stream_m_data_o, stream_m_id_o, buffer occupancy, pending-read flag, beat counter. FSM goes to IDLE. RR pointer last_gnt = N-1, so channel 0 has first priority. Any buffered or in-flight words are discarded.
- req[k] = !fifo_empty_i[k] && cfg_mask_i[k].
- FSM IDLE:
  - If any req, grant the first k with req set, searching circularly from last_gnt+1.
  - Register gnt = k, clear beat_cnt, move to BURST.
  - No reads are issued in IDLE.
- FSM BURST:
  - space = (occ + pend - pop) < 2, where occ = buffered words (0..2), pend = read issued last cycle, pop = stream_m_valid_o && stream_m_ready_i. space is combinational from ready.
  - fifo_rd_en_o[gnt] = req[gnt] && space. All other bits are 0.
  - Read issued with beat_cnt == BURST-1: last_gnt <= gnt, go to IDLE.
  - Read issued otherwise: beat_cnt++.
  - No read because req[gnt] = 0 (empty or masked): last_gnt <= gnt, go to IDLE. Masking mid-burst therefore ends the grant.
  - No read because of space only: hold state.
- Capture:
  - The edge after a read, register pend_idx.
  - The following edge, capture fifo_data_i[pend_idx] with id = pend_idx into the 2-entry buffer (output register plus skid register). Writes to the output register when it is empty or popping, otherwise to the skid register.
  - A word in flight is always captured, even if its grant has ended. Overflow is impossible by the space rule.
- Output:
  - The stream holds data/id/valid stable while valid && !ready.
  - Words leave in read order. Ids change only on word boundaries.
- Latency: req[k] seen at edge e leads to grant at e, rd_en during cycle e..e+1, and data/valid registered at edge e+2.
- Throughput:
  - With ready held high: 1 word/cycle within a burst.
  - One idle cycle per grant switch (the IDLE arbitration cycle).
- Fairness: a continuously requesting channel waits at most (N-1) bursts plus N arbitration cycles.
- Simultaneous events:
  - A pop and a capture in the same edge keep occ unchanged.
  - A grant end and a new req on the same channel: the channel still yields to any other requester.
  - Single requester: re-granted after one IDLE cycle.

Test Plan:
- Reset/idle: rst_n low mid-burst with 2 words buffered -> all outputs 0 immediately (async); after release, no rd_en while all FIFOs are empty.
- Single channel: FIFO1 holds 20 words, ready=1, BURST=8 -> reads in bursts of 8, 8, 4, each separated by one IDLE cycle; 20 words out in order with id=1; first valid 2 cycles after grant.
- Round robin: all 4 FIFOs hold 16 words each, mask=4'hF -> grant order 0,1,2,3,0,1,2,3; 8 words per grant; ids on the output follow that order.
- Backpressure: ready toggled 1,0,0,1 repeatedly -> never more than 2 words buffered plus in flight; no word lost or duplicated; data/id stable while stalled.
- Mask: cfg_mask_i bit 2 cleared mid-burst of channel 2 -> grant ends that cycle; in-flight word still delivered with id=2; channel 2 is then never granted while masked.
- Short FIFO: FIFO0 has 3 words, FIFO3 has 10 -> channel 0 releases after 3 reads (empty), channel 3 granted next; output 3 words id=0, then 8+2 words id=3.

Source files
------------

// File: rtl/stream_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// stream_fifo_arbiter
//
// Shares one outbound stream master between N standard (non-FWFT) FIFOs that
// have 1-cycle read latency. One FIFO is granted at a time, round robin. Each
// grant issues up to BURST reads. Every output word is tagged with the index
// of the FIFO it came from.
//
// Ports:
//   clk               clock
//   rst_n             asynchronous active-low reset
//   cfg_mask_i[N]     1 = channel may be granted (sampled every cycle)
//   fifo_data_i[N*DW] FIFO read data, channel k at [k*DW +: DW], valid the
//                     cycle after its read strobe
//   fifo_rd_en_o[N]   per-FIFO read strobe, at most one bit high
//   fifo_empty_i[N]   per-FIFO empty flag
//   stream_m_data_o   output word
//   stream_m_id_o     source FIFO index of the output word
//   stream_m_valid_o  output valid
//   stream_m_ready_i  consumer ready
//   dbg_state_o       arbiter FSM state (0 = IDLE, 1 = BURST)
//
// Stream handshake: a word transfers on a rising edge where valid and ready
// are both high. Once valid is raised, data, id and valid stay constant until
// that transfer; valid never depends on ready.
// -----------------------------------------------------------------------------
module stream_fifo_arbiter #(
  parameter int N     = 4,
  parameter int DW    = 32,
  parameter int BURST = 8,
  parameter int IW    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    cfg_mask_i,
  input  logic [N*DW-1:0] fifo_data_i,
  output logic [N-1:0]    fifo_rd_en_o,
  input  logic [N-1:0]    fifo_empty_i,
  output logic [DW-1:0]   stream_m_data_o,
  output logic [IW-1:0]   stream_m_id_o,
  output logic            stream_m_valid_o,
  input  logic            stream_m_ready_i,
  output logic            dbg_state_o
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_gnt;
  logic [IW-1:0] w_gnt_nxt;
  logic [IW-1:0] r_last_gnt;
  logic [IW-1:0] w_last_gnt_nxt;
  logic [CW-1:0] r_beat_cnt;
  logic [CW-1:0] w_beat_cnt_nxt;

  logic [N-1:0]  w_req;
  logic [IW-1:0] w_cand [N];
  logic [IW-1:0] w_arb_idx;
  logic          w_arb_found;
  logic          w_space;
  logic          w_rd;
  logic          w_pop;
  logic [1:0]    w_occ;

  logic          r_pend;
  logic [IW-1:0] r_pend_idx;
  logic [DW-1:0] w_fifo_word [N];
  logic [DW-1:0] w_cap_data;

  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [IW-1:0] r_out_id;
  logic          r_skid_valid;
  logic [DW-1:0] r_skid_data;
  logic [IW-1:0] r_skid_id;

  assign w_req = ~fifo_empty_i & cfg_mask_i;
  assign w_pop = r_out_valid & stream_m_ready_i;
  assign w_occ = {1'b0, r_out_valid} + {1'b0, r_skid_valid};

  // A read may only be issued if the word it returns is guaranteed a slot:
  // occ + pend - pop < 2, rearranged so nothing goes negative.
  assign w_space = ({1'b0, w_occ} + {2'b00, r_pend}) < (3'd2 + {2'b00, w_pop});

  assign w_rd = (r_state == S_BURST) && w_req[r_gnt] && w_space;

  always_comb begin
    fifo_rd_en_o = '0;
    if (w_rd) fifo_rd_en_o[r_gnt] = 1'b1;
  end

  // Candidate order for the round-robin search: last_gnt+1, last_gnt+2, ...
  for (genvar g = 0; g < N; g++) begin : g_cand
    assign w_cand[g]      = IW'((int'(r_last_gnt) + g + 1) % N);
    assign w_fifo_word[g] = fifo_data_i[g*DW +: DW];
  end

  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_arb_found && w_req[w_cand[i]]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = w_cand[i];
      end
    end
  end

  // Arbiter FSM, next-state logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_last_gnt_nxt = r_last_gnt;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_arb_found) begin
          w_gnt_nxt      = w_arb_idx;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = S_BURST;
        end
      end
      S_BURST: begin
        if (w_rd) begin
          if (r_beat_cnt == CW'(BURST - 1)) begin
            w_last_gnt_nxt = r_gnt;
            w_state_nxt    = S_IDLE;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end else if (!w_req[r_gnt]) begin
          // Granted FIFO went empty or was masked: give up the grant.
          // A stall purely for buffer space keeps the grant.
          w_last_gnt_nxt = r_gnt;
          w_state_nxt    = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_last_gnt <= IW'(N - 1);
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_last_gnt <= w_last_gnt_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // A read issued this cycle returns data next cycle; remember which FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= 1'b0;
      r_pend_idx <= '0;
    end else begin
      r_pend     <= w_rd;
      r_pend_idx <= r_gnt;
    end
  end

  assign w_cap_data = w_fifo_word[r_pend_idx];

  // Two-entry buffer: output register plus skid register, kept in read order.
  // The in-flight word is always captured, even after its grant has ended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_id     <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_id    <= '0;
    end else if (w_pop) begin
      if (r_skid_valid) begin
        r_out_data <= r_skid_data;
        r_out_id   <= r_skid_id;
        if (r_pend) begin
          r_skid_data <= w_cap_data;
          r_skid_id   <= r_pend_idx;
        end else begin
          r_skid_valid <= 1'b0;
        end
      end else if (r_pend) begin
        r_out_data <= w_cap_data;
        r_out_id   <= r_pend_idx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (r_pend) begin
      if (!r_out_valid) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_cap_data;
        r_out_id    <= r_pend_idx;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_cap_data;
        r_skid_id    <= r_pend_idx;
      end
    end
  end

  assign stream_m_data_o  = r_out_data;
  assign stream_m_id_o    = r_out_id;
  assign stream_m_valid_o = r_out_valid;
  assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_stream_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_fifo_arbiter
//
// Directed bench for stream_fifo_arbiter (N=4, DW=32, BURST=8). The bench
// plays the role of the four FIFOs (queues, 1-cycle read latency) and of the
// stream consumer. A transaction-level model turns the preloaded FIFO contents
// into the expected word order and grant runs; a single per-cycle monitor
// compares every transferred word, stall stability, read strobes and the
// occupancy bound against it. Literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_stream_fifo_arbiter;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int BURST = 8;
  localparam int IW    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    cfg_mask_i;
  logic [N*DW-1:0] fifo_data_i;
  logic [N-1:0]    fifo_rd_en_o;
  logic [N-1:0]    fifo_empty_i;
  logic [DW-1:0]   stream_m_data_o;
  logic [IW-1:0]   stream_m_id_o;
  logic            stream_m_valid_o;
  logic            stream_m_ready_i;
  logic            dbg_state_o;

  stream_fifo_arbiter #(.N(N), .DW(DW), .BURST(BURST), .IW(IW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_mask_i       (cfg_mask_i),
    .fifo_data_i      (fifo_data_i),
    .fifo_rd_en_o     (fifo_rd_en_o),
    .fifo_empty_i     (fifo_empty_i),
    .stream_m_data_o  (stream_m_data_o),
    .stream_m_id_o    (stream_m_id_o),
    .stream_m_valid_o (stream_m_valid_o),
    .stream_m_ready_i (stream_m_ready_i),
    .dbg_state_o      (dbg_state_o)
  );

  // ---------------- bench state ----------------
  logic [DW-1:0]    fq [N][$];
  logic [IW+DW-1:0] exp_q [$];
  int exp_runs [$];
  int obs_runs [$];
  int obs_gaps [$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ready_mode;
  int reads, pops;
  int rd_cnt [N];
  int run_ch, run_len, gap_len, runs_started;
  int first_rd, first_valid;
  logic [IW+DW-1:0] first_pop;
  bit               got_pop;
  bit               stall_prev;
  logic [DW-1:0]    held_data;
  logic [IW-1:0]    held_id;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, expv, cyc);
  endtask

  function automatic logic [DW-1:0] word(input int k, input int i);
    return 32'hA000_0000 + DW'(k * 65536 + i);
  endfunction

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic set_ready();
    case (ready_mode)
      0:       stream_m_ready_i = 1'b1;
      1:       stream_m_ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: stream_m_ready_i = 1'b0;
    endcase
  endtask

  task automatic load(input int k, input int n);
    for (int i = 0; i < n; i++) fq[k].push_back(word(k, i));
    fifo_empty_i[k] = (fq[k].size() == 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      fq[k].delete();
      rd_cnt[k] = 0;
    end
    fifo_empty_i = '1;
    fifo_data_i  = '0;
    cfg_mask_i   = '1;
    ready_mode   = 0;
    set_ready();
    exp_q.delete();
    exp_runs.delete();
    obs_runs.delete();
    obs_gaps.delete();
    reads = 0; pops = 0;
    run_ch = 0; run_len = 0; gap_len = 0; runs_started = 0;
    first_rd = -1; first_valid = -1; got_pop = 0;
    stall_prev = 0; held_data = '0; held_id = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Transaction-level model: round robin from channel 0, each grant takes
  // min(BURST, words left) from the chosen FIFO; ends when nothing requests.
  task automatic build_model(input logic [N-1:0] mask);
    int  rem [N];
    int  pos [N];
    int  last, sel, n;
    bit  found, done;
    for (int k = 0; k < N; k++) begin
      rem[k] = fq[k].size();
      pos[k] = 0;
    end
    last = N - 1;
    done = 0;
    while (!done) begin
      found = 0;
      sel   = 0;
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (last + i) % N;
        if (!found && mask[k] && rem[k] > 0) begin
          found = 1;
          sel   = k;
        end
      end
      if (!found) begin
        done = 1;
      end else begin
        n = (rem[sel] < BURST) ? rem[sel] : BURST;
        for (int j = 0; j < n; j++) exp_q.push_back({IW'(sel), fq[sel][pos[sel] + j]});
        pos[sel] += n;
        rem[sel] -= n;
        exp_runs.push_back(sel * 1000 + n);
        last = sel;
      end
    end
  endtask

  // ---------------- driver + monitor: one clock cycle ----------------
  task automatic cycle();
    logic [N-1:0]     rd_s;
    logic [IW+DW-1:0] e;
    logic [IW+DW-1:0] got;
    int               ch;
    @(negedge clk);
    cyc++;
    rd_s = fifo_rd_en_o;
    chk("inflight_le2", 64'((reads - pops) <= 2), 64'd1);
    if (rd_s != '0) begin
      chk("rd_onehot", 64'($onehot(rd_s)), 64'd1);
      ch = 0;
      for (int k = 0; k < N; k++) if (rd_s[k]) ch = k;
      chk("rd_not_empty", 64'(fq[ch].size() > 0), 64'd1);
      if (first_rd < 0) first_rd = cyc;
      rd_cnt[ch]++;
      reads++;
      if (run_len > 0 && ch == run_ch) begin
        run_len++;
      end else begin
        if (run_len > 0) obs_runs.push_back(run_ch * 1000 + run_len);
        if (runs_started > 0) obs_gaps.push_back(gap_len);
        runs_started++;
        run_ch  = ch;
        run_len = 1;
      end
      gap_len = 0;
    end else begin
      if (run_len > 0) begin
        obs_runs.push_back(run_ch * 1000 + run_len);
        run_len = 0;
      end
      gap_len++;
    end
    if (stall_prev) begin
      chk("stall_valid", 64'(stream_m_valid_o), 64'd1);
      chk("stall_data", 64'(stream_m_data_o), 64'(held_data));
      chk("stall_id", 64'(stream_m_id_o), 64'(held_id));
    end
    if (stream_m_valid_o && first_valid < 0) first_valid = cyc;
    if (stream_m_valid_o && stream_m_ready_i) begin
      got = {stream_m_id_o, stream_m_data_o};
      if (!got_pop) begin
        first_pop = got;
        got_pop   = 1;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      chk("word", 64'(got), 64'(e));
      pops++;
    end
    stall_prev = stream_m_valid_o && !stream_m_ready_i;
    held_data  = stream_m_data_o;
    held_id    = stream_m_id_o;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      if (rd_s[k] && fq[k].size() > 0) fifo_data_i[k*DW +: DW] = fq[k].pop_front();
    for (int k = 0; k < N; k++) fifo_empty_i[k] = (fq[k].size() == 0);
    set_ready();
  endtask

  task automatic run_until_done(input int max_cyc, input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      cycle();
      n++;
    end
    chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    repeat (8) cycle();
    chk({name, "_leftover"}, 64'(reads - pops), 64'd0);
  endtask

  task automatic check_runs_vs_model(input string name);
    chk({name, "_run_count"}, 64'(obs_runs.size()), 64'(exp_runs.size()));
    for (int i = 0; i < exp_runs.size(); i++)
      chk({name, "_run"}, 64'(at(obs_runs, i)), 64'(exp_runs[i]));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- tests ----------------
  initial begin
    int n;
    cfg_mask_i       = '1;
    fifo_data_i      = '0;
    fifo_empty_i     = '1;
    stream_m_ready_i = 1'b1;

    // Reset / idle: two words buffered under stall, then async reset.
    do_reset();
    load(0, 8);
    ready_mode = 2;
    set_ready();
    repeat (6) cycle();
    chk("pre_reset_valid", 64'(stream_m_valid_o), 64'd1);
    chk("pre_reset_buffered", 64'(reads - pops), 64'd2);
    chk("pre_reset_data", 64'(stream_m_data_o), 64'(32'hA000_0000));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(stream_m_valid_o), 64'd0);
    chk("rst_data", 64'(stream_m_data_o), 64'd0);
    chk("rst_id", 64'(stream_m_id_o), 64'd0);
    chk("rst_rd_en", 64'(fifo_rd_en_o), 64'd0);
    chk("rst_state", 64'(dbg_state_o), 64'd0);
    do_reset();
    repeat (5) begin
      cycle();
      chk("idle_no_rd", 64'(fifo_rd_en_o), 64'd0);
      chk("idle_no_valid", 64'(stream_m_valid_o), 64'd0);
    end

    // Single channel: FIFO1 with 20 words -> bursts 8, 8, 4.
    do_reset();
    load(1, 20);
    build_model('1);
    run_until_done(200, "single");
    check_runs_vs_model("single");
    chk("single_nruns_lit", 64'(obs_runs.size()), 64'd3);
    chk("single_run0_lit", 64'(at(obs_runs, 0)), 64'd1008);
    chk("single_run1_lit", 64'(at(obs_runs, 1)), 64'd1008);
    chk("single_run2_lit", 64'(at(obs_runs, 2)), 64'd1004);
    chk("single_gap0_lit", 64'(at(obs_gaps, 0)), 64'd1);
    chk("single_gap1_lit", 64'(at(obs_gaps, 1)), 64'd1);
    chk("single_latency", 64'(first_valid - first_rd), 64'd2);
    chk("single_first_word_lit", 64'(first_pop), 64'({2'd1, 32'hA001_0000}));
    chk("single_reads", 64'(rd_cnt[1]), 64'd20);

    // Round robin: four FIFOs with 16 words each.
    do_reset();
    for (int k = 0; k < N; k++) load(k, 16);
    build_model('1);
    run_until_done(300, "rr");
    check_runs_vs_model("rr");
    for (int i = 0; i < 8; i++) begin
      chk("rr_run_lit", 64'(at(obs_runs, i)), 64'((i % 4) * 1000 + 8));
      if (i < 7) chk("rr_gap_lit", 64'(at(obs_gaps, i)), 64'd1);
    end

    // Backpressure: ready pattern 1,0,0,1 with two channels.
    do_reset();
    load(0, 12);
    load(2, 9);
    build_model('1);
    ready_mode = 1;
    set_ready();
    run_until_done(400, "bp");
    chk("bp_first_word_lit", 64'(first_pop), 64'({2'd0, 32'hA000_0000}));
    chk("bp_fifo0_drained", 64'(fq[0].size()), 64'd0);
    chk("bp_fifo2_drained", 64'(fq[2].size()), 64'd0);

    // Mask: channel 2 masked after its third read.
    do_reset();
    load(2, 16);
    load(3, 4);
    for (int i = 0; i < 3; i++) exp_q.push_back({2'd2, word(2, i)});
    for (int i = 0; i < 4; i++) exp_q.push_back({2'd3, word(3, i)});
    n = 0;
    while (rd_cnt[2] < 3 && n < 40) begin
      cycle();
      n++;
    end
    chk("mask_reach_three", 64'(rd_cnt[2]), 64'd3);
    cfg_mask_i = 4'b1011;
    run_until_done(100, "mask");
    repeat (10) cycle();
    chk("mask_ch2_reads", 64'(rd_cnt[2]), 64'd3);
    chk("mask_ch2_left", 64'(fq[2].size()), 64'd13);
    chk("mask_nruns_lit", 64'(obs_runs.size()), 64'd2);
    chk("mask_run0_lit", 64'(at(obs_runs, 0)), 64'd2003);
    chk("mask_run1_lit", 64'(at(obs_runs, 1)), 64'd3004);
    chk("mask_gap0_lit", 64'(at(obs_gaps, 0)), 64'd2);

    // Short FIFO: FIFO0 has 3 words, FIFO3 has 10.
    do_reset();
    load(0, 3);
    load(3, 10);
    build_model('1);
    run_until_done(200, "short");
    check_runs_vs_model("short");
    chk("short_run0_lit", 64'(at(obs_runs, 0)), 64'd3);
    chk("short_run1_lit", 64'(at(obs_runs, 1)), 64'd3008);
    chk("short_run2_lit", 64'(at(obs_runs, 2)), 64'd3002);
    chk("short_gap0_lit", 64'(at(obs_gaps, 0)), 64'd2);
    chk("short_gap1_lit", 64'(at(obs_gaps, 1)), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
